universal_shift_register_burst: RTL

Parametrised successor to the 4-bit universal shift register: a WIDTH-bit register with hold, logical shift, parallel load, rotate and arithmetic-shift modes, plus a burst sequencer that repeats one operation a programmed number of cycles. It sits in the datapath library as the general serialiser/deserialiser and barrel-shift-by-iteration primitive.

---
 rtl/usr_pkg.sv | 17 +
 rtl/usr_next_value.sv | 31 +++
 rtl/universal_shift_register_burst.sv | 78 +++++++
 3 files changed

// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - shared op codes and FSM state encoding for the universal shift register
package usr_pkg;

  // Operation codes presented on select
  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_LOAD = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;

  // Burst sequencer states
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

endpackage

// File: rtl/usr_next_value.sv
// rtl/usr_next_value.sv - combinational next-value decode; rotate ops exist only with USR_ROTATE_EN
module usr_next_value
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  input  logic             shift_right,
  input  logic             shift_left,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] next
);

  // Select the next register value for the requested operation; anything not decoded holds
  always_comb begin
    next = d;
    case (op)
      OP_SHR:  next = {shift_right, d[WIDTH-1:1]};
      OP_SHL:  next = {d[WIDTH-2:0], shift_left};
      OP_LOAD: next = parallel_in;
`ifdef USR_ROTATE_EN
      OP_ROR:  next = {d[0], d[WIDTH-1:1]};
      OP_ROL:  next = {d[WIDTH-2:0], d[WIDTH-1]};
`endif
      OP_ASR:  next = {d[WIDTH-1], d[WIDTH-1:1]};
      default: next = d;
    endcase
  end

endmodule

// File: rtl/universal_shift_register_burst.sv
// rtl/universal_shift_register_burst.sv - WIDTH-bit universal shift register with burst sequencer (rotate via USR_ROTATE_EN)
module universal_shift_register_burst
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       select,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             shift_right,
  input  logic             shift_left,
  input  logic             burst_start,
  input  logic [LEN_W-1:0] burst_len,
  output logic [WIDTH-1:0] data_out,
  output logic             sout_right,
  output logic             sout_left,
  output logic             busy,
  output logic             done
);

  logic [0:0]       state;
  logic [2:0]       op_q;
  logic [LEN_W-1:0] counter;
  logic [2:0]       active_op;
  logic [WIDTH-1:0] next_data;

  // While a burst runs the captured op drives the datapath; live select is ignored
  assign active_op  = (state == BUSY) ? op_q : select;
  assign busy       = (state == BUSY);
  assign sout_right = data_out[0];
  assign sout_left  = data_out[WIDTH-1];

  usr_next_value #(.WIDTH(WIDTH)) u_next (
    .op          (active_op),
    .d           (data_out),
    .shift_right (shift_right),
    .shift_left  (shift_left),
    .parallel_in (parallel_in),
    .next        (next_data)
  );

  // Register, burst counter and IDLE/BUSY sequencing; done is a one-cycle flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= '0;
      state    <= IDLE;
      op_q     <= OP_HOLD;
      counter  <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (burst_start) begin
          // Start edge only arms the burst; the register moves on the following edges
          if (burst_len != '0) begin
            op_q    <= select;
            counter <= burst_len;
            state   <= BUSY;
          end else begin
            done <= 1'b1;
          end
        end else begin
          data_out <= next_data;
        end
      end else begin
        data_out <= next_data;
        counter  <= counter - LEN_W'(1);
        if (counter == LEN_W'(1)) begin
          state <= IDLE;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule
